// File: rtl/ssd_scan_driver.sv
// Converts a 13-bit binary value to four BCD digits and scans them onto a common-anode 7-seg display.
// Latency: a new value is committed to bcd/display 15 clocks after capture; the scan is continuous.
// Backpressure: none; value changes during a conversion are held off and picked up when it returns to IDLE.
// Optional leading-zero blanking is enabled by defining SSD_LZB_EN.
module ssd_scan_driver #(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic [15:0] bcd,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [12:0]             last_value;
  logic [28:0]             shreg;
  logic [28:0]             shreg_adj;
  logic [3:0]              count;
  logic [REFRESH_BITS-1:0] scan_cnt;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic                    blank;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
  always_comb begin
    shreg_adj = shreg;
    for (int i = 0; i < 4; i++) begin
      if (shreg[13 + 4*i +: 4] >= 4'd5) begin
        shreg_adj[13 + 4*i +: 4] = shreg[13 + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: capture a changed value, shift 13 times, then commit the digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bcd        <= 16'h0000;
      last_value <= 13'd0;
      shreg      <= 29'd0;
      count      <= 4'd0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (value != last_value) begin
            shreg      <= {16'b0, value};
            last_value <= value;
            count      <= 4'd0;
            state      <= CONV;
            busy       <= 1'b1;
          end
        end
        CONV: begin
          // Input never exceeds 8191, so the top bit of the adjusted register never carries out
          shreg <= shreg_adj << 1;
          count <= count + 4'd1;
          if (count == 4'd12) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Only place bcd is written, so the display never sees partial results
          bcd   <= shreg[28:13];
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running scan counter; wraps naturally from all-ones to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign sel = scan_cnt[REFRESH_BITS-1 -: 2];

  // Pick the nibble for the digit currently being driven
  always_comb begin
    digit = bcd[3:0];
    case (sel)
      2'd0: digit = bcd[3:0];
      2'd1: digit = bcd[7:4];
      2'd2: digit = bcd[11:8];
      2'd3: digit = bcd[15:12];
      default: digit = bcd[3:0];
    endcase
  end

`ifdef SSD_LZB_EN
  // Blank a digit when it and every more significant digit are zero; units always shows
  always_comb begin
    blank = 1'b0;
    case (sel)
      2'd1: blank = (bcd[15:4] == 12'd0);
      2'd2: blank = (bcd[15:8] == 8'd0);
      2'd3: blank = (bcd[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // Active-low segment decode {g,f,e,d,c,b,a}; out-of-range nibbles blank
  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      case (digit)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

  assign anode = ~(4'b0001 << sel);

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Consumes the 13-bit `ssd` debug value produced by the pipelined RISC-V top, which is selected by `ssdSel`.
- Converts it to 4-digit decimal with a sequential double-dabble engine.
- Time-multiplexes the digits onto a common-anode 4-digit seven-segment display.
- Sits between the core top and the board pins; it is the display stage downstream of the core.

Parameters:
- REFRESH_BITS, 18, width of the free-running scan counter; its top 2 bits select the active digit (2^(REFRESH_BITS-2) clocks per digit).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- value  input  13  binary value to display (0..8191)
- anode  output  4  digit enables, active-low; anode[0] = units
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- bcd  output  16  committed digits {thousands,hundreds,tens,units}, 4 bits each
- busy  output  1  high while a conversion is in flight

Behaviour:
- Clocking and reset:
  - One clock (clk); reset rst is asynchronous and active-high.
  - On rst: state=IDLE, bcd=16'h0000, last_value=0, shift count=0, scan counter=0, busy=0.
  - Outputs during/after reset: anode=4'b1110, seg=7'b1000000 ("0" on units).
- Conversion FSM, states IDLE, CONV, DONE:
  - IDLE: if value != last_value, capture value into a 29-bit shift register {16'b0,value}, set last_value=value, count=0, go to CONV. Otherwise stay.
  - CONV: each cycle, for every BCD nibble >=5 add 3, then shift the whole register left by 1; count++. After the 13th shift (count==12 at the edge) go to DONE.
  - DONE: load bcd from the BCD field, go to IDLE.
  - busy=1 in CONV and DONE, 0 in IDLE (registered from state).
- Latency:
  - Capture edge = edge 1; 13 shift edges = edges 2–14; commit edge = edge 15.
  - bcd and displayed digits change exactly 15 edges after capture; busy is high for 14 cycles.
- Input changes during CONV/DONE are ignored for the running conversion. On return to IDLE, value is compared against last_value again, so the newest value converts next with no loss of the final value.
- bcd changes only in DONE; the display never shows partially converted digits.
- Arithmetic:
  - Add-3 is applied per nibble on the pre-shift register.
  - The thousands digit never exceeds 8 (max input 8191 -> 8,1,9,1).
- Scan:
  - The counter increments every clock and wraps from all-ones to 0.
  - sel = counter[REFRESH_BITS-1 -: 2].
  - anode = ~(4'b0001 << sel); seg = decode of bcd nibble sel.
  - anode and seg are driven combinationally from registered counter and bcd.
- Decode table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other nibble = 1111111 (blank)
- rst asserted mid-conversion: conversion is abandoned and all state returns to the reset values above. After release, a non-zero value is re-captured on the first IDLE cycle.

Optional Feature:
- Macro: SSD_LZB_EN (leading-zero blanking).
- Defined:
  - While the digit is being scanned, seg=1111111 for thousands if it is 0.
  - Hundreds is blanked if thousands and hundreds are both 0.
  - Tens is blanked if thousands, hundreds and tens are all 0.
  - Units is never blanked.
  - anode scanning is unchanged; bcd output is unaffected.
- Not defined: all four digits always decode, including leading zeros.

Test Plan:
- Reset, REFRESH_BITS=4, value=0: bcd=0000, busy=0, anode sequence 1110,1101,1011,0111 every 4 clocks; seg=1000000 throughout (without SSD_LZB_EN).
- value 0->8191 after reset: busy rises after edge 1; bcd=16'h8191 exactly at edge 15; busy low after edge 15; digit sel=3 shows seg=0000000.
- value 1234, then changed to 0042 at edge 5 of the conversion: bcd becomes 1234 at edge 15, then 0042 fifteen edges after the next IDLE capture; no intermediate values on bcd.
- rst pulsed at edge 7 of a conversion of 5000: bcd=0000 immediately. After release with value still 5000, bcd=5000 fifteen edges after the first post-reset edge.
- SSD_LZB_EN defined, value=7: thousands, hundreds and tens slots seg=1111111; units seg=1111000. value=1000: all digits show.
- Scan wrap: REFRESH_BITS=4, run 64 clocks with value=9: counter wraps cleanly, anode pattern repeats with no glitch cycle, units seg=0010000.
